// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: sweeps the 3-bit select code of a 74LS138-based function
// circuit through all eight codes and captures its 1-bit output into an 8-bit
// truth table. Each code is settled, sampled once, then the decoder is blanked
// before the next code is presented.
module decoder_scan_ctrl #(
    parameter int unsigned SETTLE_CYC = 4,  // 1..255
    parameter int unsigned BLANK_CYC  = 1   // 0..255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       fn_in,
    output logic [2:0] sel,
    output logic       dec_en,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt,
    output logic       tt_valid
);

    // Counter reload values; BLANK_CYC==0 never loads the blank counter.
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] BLANK_LOAD  = (BLANK_CYC == 0) ? 8'd0 : 8'(BLANK_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StSample,
        StBlank,
        StDone
    } state_e;

    state_e     state_q;
    logic [7:0] cnt_q;
    logic [7:0] shadow_q;

    // Scan sequencer; all outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            shadow_q <= 8'd0;
            sel      <= 3'd0;
            dec_en   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tt       <= 8'h00;
            tt_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state_q != StIdle && abort) begin
                // Cancel wins over everything; tt is left untouched.
                state_q <= StIdle;
                cnt_q   <= 8'd0;
                sel     <= 3'd0;
                dec_en  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start && !abort) begin
                            state_q  <= StSettle;
                            sel      <= 3'd0;
                            dec_en   <= 1'b1;
                            busy     <= 1'b1;
                            cnt_q    <= SETTLE_LOAD;
                            shadow_q <= 8'd0;
                            tt_valid <= 1'b0;
                        end
                    end
                    StSettle: begin
                        if (cnt_q == 8'd0) begin
                            state_q <= StSample;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                    StSample: begin
                        shadow_q[sel] <= fn_in;
                        if (sel == 3'd7) begin
                            // Last bit goes straight into tt, bypassing the shadow.
                            state_q  <= StDone;
                            dec_en   <= 1'b0;
                            done     <= 1'b1;
                            tt       <= {fn_in, shadow_q[6:0]};
                            tt_valid <= 1'b1;
                        end else if (BLANK_CYC == 0) begin
                            state_q <= StSettle;
                            sel     <= sel + 3'd1;
                            cnt_q   <= SETTLE_LOAD;
                        end else begin
                            state_q <= StBlank;
                            sel     <= sel + 3'd1;
                            dec_en  <= 1'b0;
                            cnt_q   <= BLANK_LOAD;
                        end
                    end
                    StBlank: begin
                        if (cnt_q == 8'd0) begin
                            state_q <= StSettle;
                            dec_en  <= 1'b1;
                            cnt_q   <= SETTLE_LOAD;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                        sel     <= 3'd0;
                        busy    <= 1'b0;
                    end
                    default: begin
                        state_q <= StIdle;
                        sel     <= 3'd0;
                        dec_en  <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl: two instances (default timing with an
// XOR function, SETTLE_CYC=2/BLANK_CYC=0 with a majority function).
module tb_decoder_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start_a, abort_a, fn_a;
    logic       start_b, abort_b, fn_b;
    logic [2:0] sel_a, sel_b;
    logic       dec_en_a, dec_en_b, busy_a, busy_b, done_a, done_b;
    logic       tt_valid_a, tt_valid_b;
    logic [7:0] tt_a, tt_b;

    int total = 0;
    int bad   = 0;
    int viol  = 0;

    decoder_scan_ctrl #(.SETTLE_CYC(4), .BLANK_CYC(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .fn_in(fn_a),
        .sel(sel_a), .dec_en(dec_en_a), .busy(busy_a), .done(done_a),
        .tt(tt_a), .tt_valid(tt_valid_a)
    );

    decoder_scan_ctrl #(.SETTLE_CYC(2), .BLANK_CYC(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .fn_in(fn_b),
        .sel(sel_b), .dec_en(dec_en_b), .busy(busy_b), .done(done_b),
        .tt(tt_b), .tt_valid(tt_valid_b)
    );

    // Behavioural function circuits: S1^S2^S3 and majority(S1,S2,S3)
    assign fn_a = sel_a[2] ^ sel_a[1] ^ sel_a[0];
    assign fn_b = (sel_b[2] & sel_b[1]) | (sel_b[2] & sel_b[0]) | (sel_b[1] & sel_b[0]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observation mux so one scan task serves both instances
    bit         which = 1'b0;
    logic [2:0] o_sel;
    logic       o_en, o_busy, o_done, o_ttv;
    logic [7:0] o_tt;
    assign o_sel  = which ? sel_b      : sel_a;
    assign o_en   = which ? dec_en_b   : dec_en_a;
    assign o_busy = which ? busy_b     : busy_a;
    assign o_done = which ? done_b     : done_a;
    assign o_ttv  = which ? tt_valid_b : tt_valid_a;
    assign o_tt   = which ? tt_b       : tt_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (which) start_b = v;
        else       start_a = v;
    endtask

    // Whole-run monitor: sel stable while enabled (dut_a), idle outputs when not busy
    logic [2:0] psel_a = 3'd0;
    logic       pen_a  = 1'b0;
    always @(negedge clk) begin
        if (pen_a && dec_en_a && sel_a != psel_a) viol++;
        if (!busy_a && (dec_en_a || done_a || sel_a != 3'd0)) viol++;
        if (!busy_b && (dec_en_b || done_b || sel_b != 3'd0)) viol++;
        psel_a = sel_a;
        pen_a  = dec_en_a;
    end

    // Runs one scan from a negedge; n counts edges after the start-sampling edge
    task automatic scan(input bit w, input int s, input int b, input logic [7:0] exp_tt,
                        input bit poke);
        int n_exp;
        int p;
        int done_at;
        int pulses;
        int errs;
        int busy_after;
        logic       e_en;
        logic [2:0] e_sel;
        n_exp      = 8 * (s + 1) + 7 * b;
        p          = s + 1 + b;
        done_at    = -1;
        pulses     = 0;
        errs       = 0;
        busy_after = 1;
        which      = w;
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        check("start_busy", 32'(o_busy), 32'd1);
        check("start_en", 32'(o_en), 32'd1);
        for (int n = 0; n <= n_exp + 2; n++) begin
            if (n < n_exp) begin
                e_en  = (n % p) < (s + 1);
                e_sel = e_en ? 3'(n / p) : 3'(n / p + 1);
                if (o_en !== e_en || o_sel !== e_sel) errs++;
            end
            if (o_done) begin
                pulses++;
                if (done_at < 0) done_at = n;
            end
            if (n == n_exp) begin
                check("tt_at_done", 32'(o_tt), 32'(exp_tt));
                check("ttv_at_done", 32'(o_ttv), 32'd1);
            end
            if (n == n_exp + 1) busy_after = int'(o_busy);
            set_start(poke && (n == 5 || n == 20));
            @(negedge clk);
        end
        set_start(1'b0);
        check("sel_en_seq", 32'(errs), 32'd0);
        check("done_edge", 32'(done_at), 32'(n_exp));
        check("done_pulses", 32'(pulses), 32'd1);
        check("busy_fall", 32'(busy_after), 32'd0);
        check("tt_hold", 32'(o_tt), 32'(exp_tt));
    endtask

    initial begin
        int pulses;
        start_a = 1'b0; abort_a = 1'b0;
        start_b = 1'b0; abort_b = 1'b0;
        rst_n   = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        check("rst_sel", 32'(sel_a), 32'd0);
        check("rst_en", 32'(dec_en_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_tt", 32'(tt_a), 32'h00);
        check("rst_ttv", 32'(tt_valid_a), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // XOR function, default timing
        scan(1'b0, 4, 1, 8'h96, 1'b0);
        // Majority function, SETTLE_CYC=2, BLANK_CYC=0
        scan(1'b1, 2, 0, 8'hE8, 1'b0);
        check("b_ttv", 32'(tt_valid_b), 32'd1);
        // Restart pulses during a running scan are ignored
        scan(1'b0, 4, 1, 8'h96, 1'b1);

        // Abort during SETTLE of code 3
        which   = 1'b0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (19) @(negedge clk);
        check("pre_abort_sel", 32'(sel_a), 32'd3);
        check("pre_abort_en", 32'(dec_en_a), 32'd1);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        check("abort_en", 32'(dec_en_a), 32'd0);
        check("abort_sel", 32'(sel_a), 32'd0);
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_tt", 32'(tt_a), 32'h96);
        check("abort_ttv", 32'(tt_valid_a), 32'd0);
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            if (done_a) pulses++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(pulses), 32'd0);

        // Asynchronous reset while blanking between codes 1 and 2
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (11) @(negedge clk);
        check("pre_rst_blank", 32'(dec_en_a), 32'd0);
        check("pre_rst_busy", 32'(busy_a), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sel", 32'(sel_a), 32'd0);
        check("arst_en", 32'(dec_en_a), 32'd0);
        check("arst_busy", 32'(busy_a), 32'd0);
        check("arst_done", 32'(done_a), 32'd0);
        check("arst_tt", 32'(tt_a), 32'h00);
        check("arst_ttv", 32'(tt_valid_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        scan(1'b0, 4, 1, 8'h96, 1'b0);

        check("monitor", 32'(viol), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
